// File: rtl/ofm_wr_sched_if.sv
// Write-master side of the OFM scheduler: data channel toward the AXI write
// master plus the transfer request/complete handshake.
interface ofm_wr_sched_if;
  logic [511:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         wmst_req;
  logic [63:0]  wmst_addr;
  logic [63:0]  wmst_xfer_size;
  logic         wmst_done;

  modport master (
    output m_tdata, m_tvalid, wmst_req, wmst_addr, wmst_xfer_size,
    input  m_tready, wmst_done
  );

  modport slave (
    input  m_tdata, m_tvalid, wmst_req, wmst_addr, wmst_xfer_size,
    output m_tready, wmst_done
  );
endinterface

// File: rtl/ofm_wr_sched.sv
// Round-robin scheduler sharing one write master between two OFM streams:
// grants a burst, issues the request, forwards the beats, waits for completion.
module ofm_wr_sched #(
  parameter int WORD_BYTE   = 64,
  parameter int BURST_WORDS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_conv,
  input  logic [31:0]         total_words,
  input  logic [63:0]         base_addr0,
  input  logic [63:0]         base_addr1,
  input  logic                req0,
  input  logic                req1,
  input  logic [511:0]        s0_tdata,
  input  logic [511:0]        s1_tdata,
  input  logic                s0_tvalid,
  input  logic                s1_tvalid,
  output logic                s0_tready,
  output logic                s1_tready,
  ofm_wr_sched_if.master      wm,
  output logic                sel,
  output logic                busy,
  output logic                all_done
);

  localparam int BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, WAIT} state_t;

  state_t              state_reg, state_next;
  logic [31:0]         wcnt0_reg, wcnt1_reg, total_q_reg, pend_total_reg;
  logic                pend_start_reg, last_gnt_reg, sel_reg, all_done_reg;
  logic [63:0]         addr_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;

  logic fin0, fin1, elig0, elig1;
  logic start_apply, grant, gnt_sel, xfer_beat, last_beat;
  logic [63:0] gnt_addr;

  assign fin0  = (wcnt0_reg >= total_q_reg);
  assign fin1  = (wcnt1_reg >= total_q_reg);
  assign elig0 = req0 & ~fin0;
  assign elig1 = req1 & ~fin1;

  // A start (fresh or deferred) owns the IDLE cycle; no grant alongside it.
  assign start_apply = (state_reg == IDLE) & (start_conv | pend_start_reg);
  assign grant       = (state_reg == IDLE) & ~start_apply & (elig0 | elig1);
  assign gnt_sel     = (elig0 & elig1) ? ~last_gnt_reg : elig1;
  assign gnt_addr    = (gnt_sel ? base_addr1 : base_addr0)
                     + ({32'd0, (gnt_sel ? wcnt1_reg : wcnt0_reg)} * 64'(WORD_BYTE));

  assign xfer_beat = (state_reg == XFER) & (sel_reg ? s1_tvalid : s0_tvalid) & wm.m_tready;
  assign last_beat = (beat_cnt_reg == BEAT_W'(BURST_WORDS - 1));

  assign wm.wmst_addr      = addr_reg;
  assign wm.wmst_xfer_size = 64'(BURST_WORDS * WORD_BYTE);
  assign sel               = sel_reg;
  assign busy              = (state_reg != IDLE);
  assign all_done          = all_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    wm.m_tdata  = '0;
    wm.m_tvalid = 1'b0;
    wm.wmst_req = 1'b0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    case (state_reg)
      IDLE:  if (grant) state_next = ISSUE;
      ISSUE: begin
        wm.wmst_req = 1'b1;
        state_next  = XFER;
      end
      XFER: begin
        wm.m_tdata  = sel_reg ? s1_tdata : s0_tdata;
        wm.m_tvalid = sel_reg ? s1_tvalid : s0_tvalid;
        s0_tready   = ~sel_reg & wm.m_tready;
        s1_tready   = sel_reg & wm.m_tready;
        if (xfer_beat && last_beat) state_next = WAIT;
      end
      WAIT:  if (wm.wmst_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt0_reg      <= '0;
      wcnt1_reg      <= '0;
      total_q_reg    <= '0;
      pend_total_reg <= '0;
      pend_start_reg <= 1'b0;
      last_gnt_reg   <= 1'b1;
      sel_reg        <= 1'b0;
      all_done_reg   <= 1'b0;
      addr_reg       <= '0;
      beat_cnt_reg   <= '0;
    end else begin
      if (start_conv && state_reg != IDLE) begin
        pend_start_reg <= 1'b1;
        pend_total_reg <= total_words;
      end

      if (start_apply) begin
        wcnt0_reg      <= '0;
        wcnt1_reg      <= '0;
        total_q_reg    <= start_conv ? total_words : pend_total_reg;
        pend_start_reg <= 1'b0;
        all_done_reg   <= 1'b0;
      end else if (state_reg == IDLE && fin0 && fin1) begin
        all_done_reg <= 1'b1;
      end

      if (grant) begin
        sel_reg  <= gnt_sel;
        addr_reg <= gnt_addr;
      end

      if (state_reg == ISSUE)  beat_cnt_reg <= '0;
      else if (xfer_beat)      beat_cnt_reg <= beat_cnt_reg + 1'b1;

      // Completion credits the granted stream and rotates priority.
      if (state_reg == WAIT && wm.wmst_done) begin
        if (sel_reg) wcnt1_reg <= wcnt1_reg + 32'(BURST_WORDS);
        else         wcnt0_reg <= wcnt0_reg + 32'(BURST_WORDS);
        last_gnt_reg <= sel_reg;
      end
    end
  end

endmodule

// File: tb/tb_ofm_wr_sched.sv
// Scoreboarded bench for ofm_wr_sched: expected grants/addresses are queued
// as stimulus is applied and checked when the scheduler raises wmst_req.
module tb_ofm_wr_sched;
  localparam int           BURST = 2;
  localparam logic [63:0]  XSIZE = 64'd128;
  localparam logic [63:0]  BASE0 = 64'h1000;
  localparam logic [63:0]  BASE1 = 64'hFFFF_FFFF_FFFF_FFC0;
  localparam logic [511:0] D0    = {16{32'h0D0D_0000}};
  localparam logic [511:0] D1    = {16{32'h1D1D_1111}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_conv;
  logic [31:0]  total_words;
  logic [63:0]  base_addr0, base_addr1;
  logic         req0, req1;
  logic [511:0] s0_tdata, s1_tdata;
  logic         s0_tvalid, s1_tvalid, s0_tready, s1_tready;
  logic         sel, busy, all_done;

  ofm_wr_sched_if wm_if ();

  ofm_wr_sched #(.WORD_BYTE(64), .BURST_WORDS(BURST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_conv  (start_conv),
    .total_words (total_words),
    .base_addr0  (base_addr0),
    .base_addr1  (base_addr1),
    .req0        (req0),
    .req1        (req1),
    .s0_tdata    (s0_tdata),
    .s1_tdata    (s1_tdata),
    .s0_tvalid   (s0_tvalid),
    .s1_tvalid   (s1_tvalid),
    .s0_tready   (s0_tready),
    .s1_tready   (s1_tready),
    .wm          (wm_if),
    .sel         (sel),
    .busy        (busy),
    .all_done    (all_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          req_seen = 0;
  int          beats_seen = 0;
  logic        cur_sel = 1'b0;
  logic [64:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] tw);
    drive_edge();
    total_words = tw;
    start_conv  = 1'b1;
    drive_edge();
    start_conv  = 1'b0;
  endtask

  // Monitor: grant/address against the scoreboard, beat data and ready routing.
  initial begin : monitor
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wm_if.wmst_req) begin
          req_seen++;
          beats_seen = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            cur_sel = e[64];
            check("grant_sel", 64'(sel), 64'(e[64]));
            check("addr", wm_if.wmst_addr, e[63:0]);
            check("xfer_size", wm_if.wmst_xfer_size, XSIZE);
            $display("xfer %0d: sel=%0d addr=0x%0h size=%0d", req_seen, sel,
                     wm_if.wmst_addr, wm_if.wmst_xfer_size);
          end
        end
        if (wm_if.m_tvalid) begin
          check("rdy_sel", 64'(cur_sel ? s1_tready : s0_tready), 64'(wm_if.m_tready));
          check("rdy_other", 64'(cur_sel ? s0_tready : s1_tready), 64'd0);
          if (wm_if.m_tready) begin
            beats_seen++;
            check("tdata", 64'(wm_if.m_tdata == (cur_sel ? D1 : D0)), 64'd1);
          end
        end
      end
    end
  end

  // mode: 0 plain, 1 backpressure 1,0,0,1, 2 stray done in XFER, 3 start_conv in XFER
  task automatic do_xfer(input logic s, input logic [63:0] a, input int mode);
    int n0;
    bit got;
    exp_q.push_back({s, a});
    n0  = req_seen;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      sample();
      if (req_seen != n0) got = 1'b1;
    end
    if (!got) begin
      check("req_timeout", 64'd0, 64'd1);
      return;
    end
    case (mode)
      1: begin
        drive_edge(); wm_if.m_tready = 1'b1;
        drive_edge(); wm_if.m_tready = 1'b0;
        sample();     check("bp_hold_xfer", 64'(wm_if.m_tvalid), 64'd1);
        drive_edge(); wm_if.m_tready = 1'b0;
        sample();     check("bp_beats_mid", 64'(beats_seen), 64'd1);
        drive_edge(); wm_if.m_tready = 1'b1;
      end
      2: begin
        drive_edge(); wm_if.m_tready = 1'b0; wm_if.wmst_done = 1'b1;
        drive_edge(); wm_if.m_tready = 1'b1; wm_if.wmst_done = 1'b0;
        sample();     check("stray_busy", 64'(busy), 64'd1);
      end
      3: begin
        drive_edge(); start_conv = 1'b1;
        drive_edge(); start_conv = 1'b0;
      end
      default: ;
    endcase
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (beats_seen >= BURST) got = 1'b1;
      else sample();
    end
    if (!got && beats_seen < BURST) begin
      check("beat_timeout", 64'(beats_seen), 64'(BURST));
      return;
    end
    drive_edge();
    sample();
    check("wait_no_valid", 64'(wm_if.m_tvalid), 64'd0);
    check("wait_busy", 64'(busy), 64'd1);
    check("beats", 64'(beats_seen), 64'(BURST));
    drive_edge(); wm_if.wmst_done = 1'b1;
    drive_edge(); wm_if.wmst_done = 1'b0;
  endtask

  initial begin : stim
    int n0;
    bit got;
    rst_n = 1'b0;
    start_conv = 1'b0;
    total_words = '0;
    base_addr0 = BASE0;
    base_addr1 = BASE1;
    req0 = 1'b0;
    req1 = 1'b0;
    s0_tdata = D0;
    s1_tdata = D1;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    wm_if.m_tready = 1'b1;
    wm_if.wmst_done = 1'b0;

    // Reset values
    repeat (3) sample();
    check("rst_wmst_req", 64'(wm_if.wmst_req), 64'd0);
    check("rst_m_tvalid", 64'(wm_if.m_tvalid), 64'd0);
    check("rst_s0_tready", 64'(s0_tready), 64'd0);
    check("rst_s1_tready", 64'(s1_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_all_done", 64'(all_done), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_addr", wm_if.wmst_addr, 64'd0);
    check("rst_tdata", 64'(wm_if.m_tdata == '0), 64'd1);
    check("rst_xfer_size", wm_if.wmst_xfer_size, XSIZE);
    drive_edge();
    rst_n = 1'b1;

    // Single stream
    req0 = 1'b1;
    pulse_start(32'd4);
    do_xfer(1'b0, BASE0, 0);
    do_xfer(1'b0, BASE0 + 64'd128, 0);
    repeat (5) sample();
    check("single_all_done", 64'(all_done), 64'd0);
    check("single_idle", 64'(busy), 64'd0);

    // Round-robin from reset, with a stray done and backpressure folded in
    drive_edge(); rst_n = 1'b0;
    drive_edge(); drive_edge(); rst_n = 1'b1;
    req1 = 1'b1;
    pulse_start(32'd4);
    do_xfer(1'b0, BASE0, 2);
    do_xfer(1'b1, BASE1, 1);
    do_xfer(1'b0, BASE0 + 64'd128, 0);
    do_xfer(1'b1, BASE1 + 64'd128, 0);
    sample();
    check("rr_all_done_early", 64'(all_done), 64'd0);
    sample();
    check("rr_all_done_set", 64'(all_done), 64'd1);

    // Start while busy: burst finishes, then counters clear with no grant that cycle
    req1 = 1'b0;
    pulse_start(32'd4);
    sample();
    check("restart_clear", 64'(all_done), 64'd0);
    do_xfer(1'b0, BASE0, 3);
    sample();
    check("pend_idle1", 64'(busy), 64'd0);
    sample();
    check("pend_no_grant", 64'(busy), 64'd0);
    check("pend_no_req", 64'(wm_if.wmst_req), 64'd0);
    check("pend_all_done", 64'(all_done), 64'd0);
    do_xfer(1'b0, BASE0, 0);

    // Reset in the middle of a transfer
    exp_q.push_back({1'b0, BASE0 + 64'd128});
    n0 = req_seen;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      sample();
      if (req_seen != n0) got = 1'b1;
    end
    if (!got) check("mid_req_timeout", 64'd0, 64'd1);
    drive_edge();
    wm_if.m_tready = 1'b0;
    #2;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_m_tvalid", 64'(wm_if.m_tvalid), 64'd0);
    check("arst_s0_tready", 64'(s0_tready), 64'd0);
    check("arst_addr", wm_if.wmst_addr, 64'd0);
    check("arst_sel", 64'(sel), 64'd0);
    check("arst_tdata", 64'(wm_if.m_tdata == '0), 64'd1);
    drive_edge(); drive_edge();
    rst_n = 1'b1;
    wm_if.m_tready = 1'b1;

    // Zero-length conv: all_done with no request despite req0
    n0 = req_seen;
    pulse_start(32'd0);
    sample();
    check("zero_clear", 64'(all_done), 64'd0);
    sample();
    check("zero_all_done", 64'(all_done), 64'd1);
    repeat (5) sample();
    check("zero_no_req", 64'(req_seen), 64'(n0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
